fir_deconv: RTL and testbench
=============================

FIR_DECONV -- requirements
Module: fir_deconv

Interface
REQ-001 SHALL have parameter width, default 8, giving the sample and weight width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port y_in, input, 2*width, the filtered sample to invert (unsigned).
REQ-005 SHALL have port y_valid, input, 1, meaning y_in holds a sample.
REQ-006 SHALL have port y_ready, output, 1, meaning the block accepts y_in this cycle.
REQ-007 SHALL have ports w_1, w_2, w_3, input, width each, the unsigned tap weights of the forward filter.
REQ-008 SHALL have port x_out, output, width, the recovered sample.
REQ-009 SHALL have port x_valid, output, 1, a one-cycle pulse marking x_out valid.
REQ-010 SHALL have port err_div0, output, 1, meaning w_1 was zero for this result; valid with x_valid.
REQ-011 SHALL have port err_range, output, 1, meaning the residual was negative or the quotient exceeded width bits; valid with x_valid.

Function
REQ-012 SHALL invert y[n] = w_1*x[n-1] + w_2*x[n-2] + w_3*x[n-3] by computing x = (y - w_2*h1 - w_3*h2) / w_1; h1 is the last recovered x and h2 the one before.
REQ-013 SHALL implement states IDLE, CALC, DIV and OUT; the reset state is IDLE.
REQ-014 SHALL drive y_ready high only in IDLE; a handshake is y_valid and y_ready high at a posedge.
REQ-015 SHALL, on a handshake, latch y_in, w_1, w_2 and w_3 and go IDLE->CALC; weight changes after that edge do not affect the result.
REQ-016 SHALL, in CALC, form the residual in at least 2*width+2 bits, then go CALC->DIV.
- Residual negative: x=0, err_range=1, DIV skipped (go to OUT).
- Latched w_1 == 0: x=0, err_div0=1, DIV skipped; err_div0 takes priority over err_range.
REQ-017 SHALL, in DIV, perform an unsigned restoring division of the 2*width-bit residual by w_1, one quotient bit per cycle, for exactly 2*width cycles, then go DIV->OUT.
REQ-018 SHALL truncate the quotient (discard the remainder); a quotient above 2^width-1 saturates x to 2^width-1 with err_range=1.
REQ-019 SHALL, in OUT, present x_out with x_valid high for one cycle, then go OUT->IDLE.
- x_valid is not held for a stalled consumer.
- x_out, err_div0 and err_range hold their values until the next OUT.
REQ-020 SHALL, in OUT, update history: h2<=h1, h1<=x; when either error flag is set, the pushed x is the reported x_out (0 or the saturated value).
REQ-021 SHALL have a handshake-to-result latency of exactly 2*width+2 posedges in the non-skipped path.
- Handshake at edge k puts x_valid high after edge k+2*width+2.
- Skipped path: x_valid high after edge k+2.
REQ-022 SHALL have a maximum throughput of one sample per 2*width+3 cycles; y_valid while busy is ignored, and the source must hold y_in until the handshake.

Reset
REQ-023 SHALL, while rst is high, force state=IDLE, y_ready=1, x_valid=0, x_out=0, err_div0=0, err_range=0, h1=h2=0, and clear the divider registers.
REQ-024 SHALL, on rst asserted mid-operation (any state), abort the calculation without emitting x_valid; the first handshake after rst deasserts uses zero history.

Verification
REQ-025 SHALL verify the nominal sequence: width=8, w=(2,3,1), reset, then y_in 10, 29, 34 -> x_out 5, 7, 4, each x_valid 18 edges after its handshake, no error flags.
REQ-026 SHALL verify divide-by-zero: w_1=0, y_in=100 -> x_out=0, err_div0=1, x_valid 2 edges after the handshake, and h1 becomes 0.
REQ-027 SHALL verify saturation: w=(1,0,0), zero history, y_in=300 -> x_out=255, err_range=1.
REQ-028 SHALL verify negative residual: w=(1,1,0), after recovering x=5 from y_in=5, send y_in=3 -> x_out=0, err_range=1.
REQ-029 SHALL verify busy and weight latching: y_valid held high through a computation gives y_ready=0 from CALC to OUT and only one result per handshake; changing w_1 from 2 to 7 during DIV leaves the result unaffected.
REQ-030 SHALL verify reset mid-DIV: assert rst in DIV cycle 5 -> no x_valid, all outputs 0; then y_in=10 with w=(2,3,1) -> x_out=5.

Source files
------------

// File: rtl/fir_deconv.sv
// rtl/fir_deconv.sv - inverse of a 3-tap FIR: recovers x[n-1] from y[n] using a serial restoring divider
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   y_in       filtered sample to invert (2*width bits, unsigned)
//   y_valid    y_in holds a sample
//   y_ready    block accepts y_in this cycle (high only while idle)
//   w_1..w_3   unsigned forward-filter tap weights, latched on the handshake
//   x_out      recovered sample, held until the next result
//   x_valid    one-cycle pulse marking a new x_out
//   err_div0   latched w_1 was zero for this result
//   err_range  negative residual or quotient wider than width bits
module fir_deconv #(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*width-1:0]   y_in,
  input  logic                 y_valid,
  output logic                 y_ready,
  input  logic [width-1:0]     w_1,
  input  logic [width-1:0]     w_2,
  input  logic [width-1:0]     w_3,
  output logic [width-1:0]     x_out,
  output logic                 x_valid,
  output logic                 err_div0,
  output logic                 err_range
);

  localparam int YW = 2 * width;          // sample / dividend width
  localparam int RW = 2 * width + 2;      // residual width, enough for y - 2*max_product
  localparam int CW = $clog2(2 * width + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(2 * width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [YW-1:0]    y_q, y_d;
  logic [width-1:0] w1_q, w1_d;
  logic [width-1:0] w2_q, w2_d;
  logic [width-1:0] w3_q, w3_d;
  logic [width-1:0] h1_q, h1_d;
  logic [width-1:0] h2_q, h2_d;
  logic [YW-1:0]    dvd_q, dvd_d;
  logic [width-1:0] rem_q, rem_d;
  logic [YW-1:0]    quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_div0_q, pend_div0_d;
  logic             pend_range_q, pend_range_d;
  logic [width-1:0] x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             err_div0_q, err_div0_d;
  logic             err_range_q, err_range_d;
  logic             y_ready_q, y_ready_d;

  // Datapath helpers
  logic [YW-1:0]    prod2, prod3;
  logic [RW-1:0]    residual;
  logic             res_bad;
  logic [width:0]   div_sh;
  logic             div_ge;
  logic [width-1:0] div_sub;
  logic [width-1:0] res_x;
  logic             res_div0, res_range;

  always_comb begin
    prod2    = {{width{1'b0}}, w2_q} * {{width{1'b0}}, h1_q};
    prod3    = {{width{1'b0}}, w3_q} * {{width{1'b0}}, h2_q};
    residual = {2'b00, y_q} - {2'b00, prod2} - {2'b00, prod3};
    // A non-negative residual is at most y, so bit YW can only be set
    // together with the sign bit; folding it in keeps the test exact.
    res_bad  = residual[RW-1] | residual[YW];

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    div_sh   = {rem_q, dvd_q[YW-1]};
    div_ge   = (div_sh >= {1'b0, w1_q});
    div_sub  = width'(div_sh - {1'b0, w1_q});

    // Result selection for OUT; div0 outranks the range error.
    res_x     = quo_q[width-1:0];
    res_div0  = 1'b0;
    res_range = 1'b0;
    if (pend_div0_q) begin
      res_x    = '0;
      res_div0 = 1'b1;
    end else if (pend_range_q) begin
      res_x     = '0;
      res_range = 1'b1;
    end else if (|quo_q[YW-1:width]) begin
      res_x     = '1;
      res_range = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    h1_d         = h1_q;
    h2_d         = h2_q;
    dvd_d        = dvd_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    pend_div0_d  = pend_div0_q;
    pend_range_d = pend_range_q;
    x_out_d      = x_out_q;
    x_valid_d    = 1'b0;
    err_div0_d   = err_div0_q;
    err_range_d  = err_range_q;

    unique case (state_q)
      IDLE: begin
        if (y_valid && y_ready_q) begin
          y_d     = y_in;
          w1_d    = w_1;
          w2_d    = w_2;
          w3_d    = w_3;
          state_d = CALC;
        end
      end
      CALC: begin
        pend_div0_d  = (w1_q == '0);
        pend_range_d = (w1_q != '0) && res_bad;
        dvd_d        = residual[YW-1:0];
        rem_d        = '0;
        quo_d        = '0;
        cnt_d        = '0;
        state_d      = ((w1_q == '0) || res_bad) ? OUT : DIV;
      end
      DIV: begin
        rem_d = div_ge ? div_sub : div_sh[width-1:0];
        quo_d = {quo_q[YW-2:0], div_ge};
        dvd_d = {dvd_q[YW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          state_d = OUT;
        end
      end
      OUT: begin
        x_out_d     = res_x;
        err_div0_d  = res_div0;
        err_range_d = res_range;
        x_valid_d   = 1'b1;
        h2_d        = h1_q;
        h1_d        = res_x;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    y_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      y_q          <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      h1_q         <= '0;
      h2_q         <= '0;
      dvd_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      pend_div0_q  <= 1'b0;
      pend_range_q <= 1'b0;
      x_out_q      <= '0;
      x_valid_q    <= 1'b0;
      err_div0_q   <= 1'b0;
      err_range_q  <= 1'b0;
      y_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      dvd_q        <= dvd_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      pend_div0_q  <= pend_div0_d;
      pend_range_q <= pend_range_d;
      x_out_q      <= x_out_d;
      x_valid_q    <= x_valid_d;
      err_div0_q   <= err_div0_d;
      err_range_q  <= err_range_d;
      y_ready_q    <= y_ready_d;
    end
  end

  assign y_ready   = y_ready_q;
  assign x_out     = x_out_q;
  assign x_valid   = x_valid_q;
  assign err_div0  = err_div0_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_fir_deconv.sv
// tb/tb_fir_deconv.sv - self-checking bench for fir_deconv
module tb_fir_deconv;
  localparam int W    = 8;
  localparam int LAT  = 2 * W + 2;
  localparam int LATS = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*W-1:0] y_in;
  logic           y_valid;
  logic           y_ready;
  logic [W-1:0]   w_1, w_2, w_3;
  logic [W-1:0]   x_out;
  logic           x_valid;
  logic           err_div0;
  logic           err_range;

  fir_deconv #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
    .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .x_out(x_out), .x_valid(x_valid),
    .err_div0(err_div0), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int mh1    = 0;
  int mh2    = 0;

  typedef struct {
    bit rst_b;
    int y, w1, w2, w3;
    int x, d0, rg, lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: solve the FIR equation for the newest input sample.
  task automatic model(input int y, input int w1, input int w2, input int w3,
                       output int x, output int d0, output int rg, output int lat);
    int r;
    r   = y - w2 * mh1 - w3 * mh2;
    d0  = 0;
    rg  = 0;
    lat = LAT;
    if (w1 == 0) begin
      x = 0; d0 = 1; lat = LATS;
    end else if (r < 0) begin
      x = 0; rg = 1; lat = LATS;
    end else begin
      x = r / w1;
      if (x > 255) begin
        x = 255; rg = 1;
      end
    end
    mh2 = mh1;
    mh1 = x;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    y_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {20'd0, y_ready, x_valid, err_div0, err_range, x_out}, 32'h800);
    rst = 1'b0;
    mh1 = 0;
    mh2 = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int y, input int w1, input int w2, input int w3,
                         output int x, output int d0, output int rg, output int lat);
    int t;
    y_in    = 16'(y);
    w_1     = 8'(w1);
    w_2     = 8'(w2);
    w_3     = 8'(w3);
    y_valid = 1'b1;
    t       = 0;
    x = -1; d0 = -1; rg = -1; lat = -1;
    while (!y_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!y_ready) begin
      check("handshake_timeout", 0, 1);
      y_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    y_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (x_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      check("result_timeout", 0, 1);
      return;
    end
    x  = int'(x_out);
    d0 = int'(err_div0);
    rg = int'(err_range);
    @(posedge clk);
    #1;
    check("x_valid_pulse", x_valid, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, d0, rg, lat;
    int ex, ed0, erg, elat;
    int lows, pulses;

    tbl[0] = '{1, 10,  2, 3, 1,   5, 0, 0, LAT};
    tbl[1] = '{0, 29,  2, 3, 1,   7, 0, 0, LAT};
    tbl[2] = '{0, 34,  2, 3, 1,   4, 0, 0, LAT};
    tbl[3] = '{1, 10,  2, 3, 1,   5, 0, 0, LAT};
    tbl[4] = '{0, 100, 0, 3, 1,   0, 1, 0, LATS};
    tbl[5] = '{0, 3,   1, 1, 0,   3, 0, 0, LAT};   // h1 was cleared by the div0 result
    tbl[6] = '{1, 300, 1, 0, 0, 255, 0, 1, LAT};
    tbl[7] = '{1, 5,   1, 1, 0,   5, 0, 0, LAT};
    tbl[8] = '{0, 3,   1, 1, 0,   0, 0, 1, LATS};
    tbl[9] = '{0, 0,   0, 0, 1,   0, 1, 0, LATS};  // negative residual and w_1=0: div0 wins

    rst = 1'b1; y_valid = 1'b0; y_in = '0; w_1 = '0; w_2 = '0; w_3 = '0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_b) do_reset();
      run_one(tbl[i].y, tbl[i].w1, tbl[i].w2, tbl[i].w3, x, d0, rg, lat);
      check($sformatf("vec%0d_x", i),     x,   tbl[i].x);
      check($sformatf("vec%0d_div0", i),  d0,  tbl[i].d0);
      check($sformatf("vec%0d_range", i), rg,  tbl[i].rg);
      check($sformatf("vec%0d_lat", i),   lat, tbl[i].lat);
    end

    // Busy behaviour and weight latching with y_valid held high.
    do_reset();
    y_in = 16'd10; w_1 = 8'd2; w_2 = 8'd3; w_3 = 8'd1; y_valid = 1'b1;
    @(posedge clk);
    #1;
    lows = 0; pulses = 0;
    for (int n = 0; n < LAT; n++) begin
      if (!y_ready) lows++;
      if (x_valid) pulses++;
      if (n == 5) w_1 = 8'd7;
      @(posedge clk);
      #1;
    end
    check("busy_ready_low", lows, LAT);
    check("busy_early_pulse", pulses, 0);
    check("busy_x_valid", x_valid, 1);
    check("busy_x_out", x_out, 5);
    check("busy_ready_back", y_ready, 1);
    y_valid = 1'b0;
    pulses  = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (x_valid) pulses++;
    end
    check("busy_extra_pulse", pulses, 0);

    // Reset in the middle of a division.
    do_reset();
    run_one(10, 2, 3, 1, x, d0, rg, lat);
    check("pre_abort_x", x, 5);
    y_in = 16'd10; y_valid = 1'b1;
    @(posedge clk);
    #1;
    y_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", {20'd0, y_ready, x_valid, err_div0, err_range, x_out}, 32'h800);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mh1 = 0; mh2 = 0;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (x_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    run_one(10, 2, 3, 1, x, d0, rg, lat);
    check("post_abort_x", x, 5);
    check("post_abort_lat", lat, LAT);

    // Randomized sequence against the reference model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int w1, w2, w3, y, xr;
      w1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) begin
        w2 = int'($urandom_range(0, 15));
        w3 = int'($urandom_range(0, 15));
      end else begin
        w2 = int'($urandom_range(0, 255));
        w3 = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1) begin
        xr = int'($urandom_range(0, 255));
        y  = w1 * xr + w2 * mh1 + w3 * mh2;
        if (y > 65535) y = int'($urandom_range(0, 65535));
      end else begin
        y = int'($urandom_range(0, 65535));
      end
      model(y, w1, w2, w3, ex, ed0, erg, elat);
      run_one(y, w1, w2, w3, x, d0, rg, lat);
      check($sformatf("rnd%0d_x", i),     x,   ex);
      check($sformatf("rnd%0d_div0", i),  d0,  ed0);
      check($sformatf("rnd%0d_range", i), rg,  erg);
      check($sformatf("rnd%0d_lat", i),   lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
